// File: rtl/memory_bank_loader.sv
// Streams SW-bit words into a banked memory starting at a latched base address.
// Each accepted word becomes one registered write; done coincides with the last write.
module memory_bank_loader #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64,
    parameter int BANKS = 4,
    localparam int AW = DEPTH + $clog2(BANKS),
    localparam int SW = WIDTH / BANKS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    input  logic          in_valid,
    input  logic [SW-1:0] in_data,
    output logic          in_ready,
    output logic          write_enable,
    output logic [AW-1:0] write_addr,
    output logic [SW-1:0] data_in,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   remain_q, remain_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [SW-1:0] wdata_q, wdata_d;

    // Next-state, counter update and write-register capture.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = count;
                    state_d  = (count == CNT_ZERO) ? FINISH : LOAD;
                end else begin
                    state_d  = IDLE;
                end
            end
            LOAD: begin
                // The write goes to the pre-increment address; the counter moves on.
                if (in_valid) begin
                    we_d     = 1'b1;
                    waddr_d  = addr_q;
                    wdata_d  = in_data;
                    addr_d   = addr_q + ADDR_ONE;
                    remain_d = remain_q - CNT_ONE;
                    state_d  = (remain_q == CNT_ONE) ? FINISH : LOAD;
                end else begin
                    state_d  = LOAD;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and the write output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= {AW{1'b0}};
            remain_q <= {(AW+1){1'b0}};
            we_q     <= 1'b0;
            waddr_q  <= {AW{1'b0}};
            wdata_q  <= {SW{1'b0}};
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign in_ready     = (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FINISH);
    assign write_enable = we_q;
    assign write_addr   = waddr_q;
    assign data_in      = wdata_q;

endmodule
